// File: rtl/cpu64_obi_pkg.sv
// Shared host identifiers and helpers for the cpu64 OBI arbiter.
package cpu64_obi_pkg;

    typedef logic [0:0] host_id_t;

    localparam int unsigned NUM_HOSTS  = 2;
    localparam host_id_t    HOST_DATA  = 1'b0;
    localparam host_id_t    HOST_FETCH = 1'b1;

    function automatic host_id_t other_host(input host_id_t id);
        return (id == HOST_DATA) ? HOST_FETCH : HOST_DATA;
    endfunction

endpackage

// File: rtl/cpu64_obi_owner_fifo.sv
// In-order owner FIFO: remembers which host issued each outstanding read.
module cpu64_obi_owner_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic [WIDTH-1:0]           head_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok_s, pop_ok_s;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign head_o    = mem_q[rd_ptr_q];
    assign push_ok_s = push_i && !full_o;
    assign pop_ok_s  = pop_i && !empty_o;

    // Pointer and occupancy next-state; push and pop together leave count unchanged.
    always_comb begin
        wr_ptr_d = push_ok_s ? next_ptr(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop_ok_s  ? next_ptr(rd_ptr_q) : rd_ptr_q;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO storage, pointers and count.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_ok_s) begin
                mem_q[wr_ptr_q] <= push_data_i;
            end
        end
    end

endmodule

// File: rtl/cpu64_obi_arbiter.sv
// Two-host to one-device OBI arbiter with request lock and in-order read routing.
// Build option: CPU64_OBI_ARB_RR_EN selects round-robin instead of fixed priority (data host first).
module cpu64_obi_arbiter
    import cpu64_obi_pkg::*;
#(
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned ADDR_W    = 39,
    parameter int unsigned BE_BITS   = DATA_W / 8,
    parameter int unsigned MAX_OUTST = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               h0_req_i,
    input  logic               h0_we_i,
    input  logic [BE_BITS-1:0] h0_be_i,
    input  logic [ADDR_W-1:0]  h0_addr_i,
    input  logic [DATA_W-1:0]  h0_wdata_i,
    output logic               h0_gnt_o,
    output logic               h0_rvalid_o,
    output logic [DATA_W-1:0]  h0_rdata_o,
    input  logic               h1_req_i,
    input  logic               h1_we_i,
    input  logic [BE_BITS-1:0] h1_be_i,
    input  logic [ADDR_W-1:0]  h1_addr_i,
    input  logic [DATA_W-1:0]  h1_wdata_i,
    output logic               h1_gnt_o,
    output logic               h1_rvalid_o,
    output logic [DATA_W-1:0]  h1_rdata_o,
    output logic               req_o,
    output logic               we_o,
    output logic [BE_BITS-1:0] be_o,
    output logic [ADDR_W-1:0]  addr_o,
    output logic [DATA_W-1:0]  wdata_o,
    input  logic               gnt_i,
    input  logic               rvalid_i,
    input  logic [DATA_W-1:0]  rdata_i,
    output logic               err_o
);

    localparam int unsigned CNT_W       = $clog2(MAX_OUTST) + 1;
    localparam logic [0:0]  ST_UNLOCKED = 1'b0;
    localparam logic [0:0]  ST_LOCKED   = 1'b1;

    logic [0:0]       lock_q, lock_d;
    host_id_t         lock_id_q, lock_id_d;
    logic             err_q, err_d;
    host_id_t         sel_s;
    logic             hsel_req_s;
    logic             accept_s;
    logic             push_s, pop_s;
    logic             full_s, empty_s;
    logic [CNT_W-1:0] count_s;
    host_id_t         head_s;
`ifdef CPU64_OBI_ARB_RR_EN
    host_id_t         rr_q, rr_d;
`endif

    // Host selection: a held lock wins, otherwise the arbitration policy.
    always_comb begin
        sel_s = HOST_DATA;
        if (lock_q == ST_LOCKED) begin
            sel_s = lock_id_q;
        end else if (h0_req_i && h1_req_i) begin
`ifdef CPU64_OBI_ARB_RR_EN
            sel_s = rr_q;
`else
            sel_s = HOST_DATA;
`endif
        end else if (h1_req_i) begin
            sel_s = HOST_FETCH;
        end else begin
            sel_s = HOST_DATA;
        end
    end

    // Request-phase mux from the selected host; host 0 when nobody requests.
    always_comb begin
        case (sel_s)
            HOST_FETCH: begin
                hsel_req_s = h1_req_i;
                we_o       = h1_we_i;
                be_o       = h1_be_i;
                addr_o     = h1_addr_i;
                wdata_o    = h1_wdata_i;
            end
            default: begin
                hsel_req_s = h0_req_i;
                we_o       = h0_we_i;
                be_o       = h0_be_i;
                addr_o     = h0_addr_i;
                wdata_o    = h0_wdata_i;
            end
        endcase
    end

    // A full owner FIFO blocks new requests even if a response pops this cycle.
    assign req_o    = hsel_req_s && (count_s < CNT_W'(MAX_OUTST));
    assign accept_s = req_o && gnt_i;
    assign push_s   = accept_s && !we_o;
    assign pop_s    = rvalid_i && !empty_s;

    assign h0_gnt_o    = accept_s && (sel_s == HOST_DATA);
    assign h1_gnt_o    = accept_s && (sel_s == HOST_FETCH);
    assign h0_rvalid_o = pop_s && (head_s == HOST_DATA);
    assign h1_rvalid_o = pop_s && (head_s == HOST_FETCH);
    assign h0_rdata_o  = rdata_i;
    assign h1_rdata_o  = rdata_i;
    assign err_o       = err_q;

    // Lock FSM keeps the request phase stable until the device grants it.
    always_comb begin
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        case (lock_q)
            ST_UNLOCKED: begin
                if (req_o && !gnt_i) begin
                    lock_d    = ST_LOCKED;
                    lock_id_d = sel_s;
                end else begin
                    lock_d    = ST_UNLOCKED;
                end
            end
            ST_LOCKED: begin
                if (accept_s || !hsel_req_s) begin
                    lock_d = ST_UNLOCKED;
                end else begin
                    lock_d = ST_LOCKED;
                end
            end
            default: begin
                lock_d = ST_UNLOCKED;
            end
        endcase
    end

    // Spurious responses latch an error that only reset clears.
    always_comb begin
        err_d = err_q || (rvalid_i && empty_s);
`ifdef CPU64_OBI_ARB_RR_EN
        rr_d  = accept_s ? other_host(sel_s) : rr_q;
`endif
    end

    // Arbiter state registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            lock_q    <= ST_UNLOCKED;
            lock_id_q <= HOST_DATA;
            err_q     <= 1'b0;
`ifdef CPU64_OBI_ARB_RR_EN
            rr_q      <= HOST_DATA;
`endif
        end else begin
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
            err_q     <= err_d;
`ifdef CPU64_OBI_ARB_RR_EN
            rr_q      <= rr_d;
`endif
        end
    end

    cpu64_obi_owner_fifo #(
        .DEPTH (MAX_OUTST),
        .WIDTH (1)
    ) u_owner_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (push_s),
        .push_data_i (sel_s),
        .pop_i       (pop_s),
        .full_o      (full_s),
        .empty_o     (empty_s),
        .count_o     (count_s),
        .head_o      (head_s)
    );

endmodule

// File: tb/tb_cpu64_obi_arbiter.sv
// Directed self-checking bench for cpu64_obi_arbiter (either arbitration build).
module tb_cpu64_obi_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        h0_req_i, h0_we_i, h1_req_i, h1_we_i;
    logic [7:0]  h0_be_i, h1_be_i, be_o;
    logic [38:0] h0_addr_i, h1_addr_i, addr_o;
    logic [63:0] h0_wdata_i, h1_wdata_i, wdata_o, h0_rdata_o, h1_rdata_o, rdata_i;
    logic        h0_gnt_o, h0_rvalid_o, h1_gnt_o, h1_rvalid_o;
    logic        req_o, we_o, gnt_i, rvalid_i, err_o;
    int          checks = 0;
    int          errors = 0;

    always #5 clk_i = ~clk_i;

    cpu64_obi_arbiter dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .h0_req_i(h0_req_i), .h0_we_i(h0_we_i), .h0_be_i(h0_be_i), .h0_addr_i(h0_addr_i),
        .h0_wdata_i(h0_wdata_i), .h0_gnt_o(h0_gnt_o), .h0_rvalid_o(h0_rvalid_o), .h0_rdata_o(h0_rdata_o),
        .h1_req_i(h1_req_i), .h1_we_i(h1_we_i), .h1_be_i(h1_be_i), .h1_addr_i(h1_addr_i),
        .h1_wdata_i(h1_wdata_i), .h1_gnt_o(h1_gnt_o), .h1_rvalid_o(h1_rvalid_o), .h1_rdata_o(h1_rdata_o),
        .req_o(req_o), .we_o(we_o), .be_o(be_o), .addr_o(addr_o), .wdata_o(wdata_o),
        .gnt_i(gnt_i), .rvalid_i(rvalid_i), .rdata_i(rdata_i), .err_o(err_o)
    );

    task automatic idle();
        h0_req_i = 1'b0; h0_we_i = 1'b0; h0_be_i = 8'hFF; h0_addr_i = 39'h0; h0_wdata_i = 64'h0;
        h1_req_i = 1'b0; h1_we_i = 1'b0; h1_be_i = 8'hFF; h1_addr_i = 39'h0; h1_wdata_i = 64'h0;
        gnt_i = 1'b0; rvalid_i = 1'b0; rdata_i = 64'h0;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        idle();
        rst_ni = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        idle();
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        gnt_i = 1'b1;
        #1;
        checks++; if (req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %b exp 0", req_o); end
        checks++; if ({h0_gnt_o, h1_gnt_o} !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b exp 00", {h0_gnt_o, h1_gnt_o}); end
        checks++; if ({h0_rvalid_o, h1_rvalid_o} !== 2'b00) begin errors++; $display("FAIL reset_rvalid: got %b exp 00", {h0_rvalid_o, h1_rvalid_o}); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b exp 0", err_o); end
        gnt_i = 1'b0;
    endtask

    task automatic test_single_read();
        do_reset();
        @(negedge clk_i);
        h1_req_i = 1'b1; h1_addr_i = 39'h100; gnt_i = 1'b1;
        #1;
        checks++; if (h1_gnt_o !== 1'b1) begin errors++; $display("FAIL single_h1_gnt: got %b exp 1", h1_gnt_o); end
        checks++; if (h0_gnt_o !== 1'b0) begin errors++; $display("FAIL single_h0_gnt: got %b exp 0", h0_gnt_o); end
        checks++; if (addr_o !== 39'h100) begin errors++; $display("FAIL single_addr: got %h exp 100", addr_o); end
        @(negedge clk_i);
        h1_req_i = 1'b0; gnt_i = 1'b0;
        #1;
        checks++; if ({h0_rvalid_o, h1_rvalid_o} !== 2'b00) begin errors++; $display("FAIL single_rvalid_c1: got %b exp 00", {h0_rvalid_o, h1_rvalid_o}); end
        @(negedge clk_i);
        rvalid_i = 1'b1; rdata_i = 64'hDEAD;
        #1;
        checks++; if (h1_rvalid_o !== 1'b1) begin errors++; $display("FAIL single_h1_rvalid: got %b exp 1", h1_rvalid_o); end
        checks++; if (h0_rvalid_o !== 1'b0) begin errors++; $display("FAIL single_h0_rvalid: got %b exp 0", h0_rvalid_o); end
        checks++; if (h1_rdata_o !== 64'hDEAD) begin errors++; $display("FAIL single_rdata: got %h exp dead", h1_rdata_o); end
        @(negedge clk_i);
        rvalid_i = 1'b0;
        #1;
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL single_err: got %b exp 0", err_o); end
    endtask

    task automatic test_contention_lock();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            h1_req_i = 1'b1; h1_addr_i = 39'h200; gnt_i = 1'b0;
            #1;
            checks++; if (addr_o !== 39'h200) begin errors++; $display("FAIL lock_addr_c%0d: got %h exp 200", c, addr_o); end
            checks++; if (h1_gnt_o !== 1'b0) begin errors++; $display("FAIL lock_nogrant_c%0d: got %b exp 0", c, h1_gnt_o); end
        end
        @(negedge clk_i);
        h0_req_i = 1'b1; h0_addr_i = 39'h300; gnt_i = 1'b1;
        #1;
        checks++; if (addr_o !== 39'h200) begin errors++; $display("FAIL lock_addr_c3: got %h exp 200", addr_o); end
        checks++; if ({h0_gnt_o, h1_gnt_o} !== 2'b01) begin errors++; $display("FAIL lock_gnt_c3: got %b exp 01", {h0_gnt_o, h1_gnt_o}); end
        @(negedge clk_i);
        h1_req_i = 1'b0;
        #1;
        checks++; if ({h0_gnt_o, h1_gnt_o} !== 2'b10) begin errors++; $display("FAIL lock_gnt_c4: got %b exp 10", {h0_gnt_o, h1_gnt_o}); end
        checks++; if (addr_o !== 39'h300) begin errors++; $display("FAIL lock_addr_c4: got %h exp 300", addr_o); end
        @(negedge clk_i);
        h0_req_i = 1'b0; gnt_i = 1'b0; rvalid_i = 1'b1;
        #1;
        checks++; if ({h0_rvalid_o, h1_rvalid_o} !== 2'b01) begin errors++; $display("FAIL lock_resp1: got %b exp 01", {h0_rvalid_o, h1_rvalid_o}); end
        @(negedge clk_i);
        #1;
        checks++; if ({h0_rvalid_o, h1_rvalid_o} !== 2'b10) begin errors++; $display("FAIL lock_resp2: got %b exp 10", {h0_rvalid_o, h1_rvalid_o}); end
        @(negedge clk_i);
        rvalid_i = 1'b0;
    endtask

    task automatic test_simultaneous();
        logic [1:0] exp_gnt;
        do_reset();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i);
            h0_req_i = 1'b1; h0_we_i = 1'b1; h0_addr_i = 39'h10; h0_wdata_i = 64'hAAAA;
            h1_req_i = 1'b1; h1_we_i = 1'b1; h1_addr_i = 39'h20; h1_wdata_i = 64'hBBBB;
            gnt_i = 1'b1;
`ifdef CPU64_OBI_ARB_RR_EN
            exp_gnt = (c % 2 == 0) ? 2'b10 : 2'b01;
`else
            exp_gnt = 2'b10;
`endif
            #1;
            checks++; if ({h0_gnt_o, h1_gnt_o} !== exp_gnt) begin errors++; $display("FAIL simul_gnt_c%0d: got %b exp %b", c, {h0_gnt_o, h1_gnt_o}, exp_gnt); end
            checks++; if (wdata_o !== (exp_gnt[1] ? 64'hAAAA : 64'hBBBB)) begin errors++; $display("FAIL simul_wdata_c%0d: got %h", c, wdata_o); end
        end
        checks++; if (we_o !== 1'b1) begin errors++; $display("FAIL simul_we: got %b exp 1", we_o); end
    endtask

    task automatic test_ordered_routing();
        do_reset();
        @(negedge clk_i);
        h0_req_i = 1'b1; h0_addr_i = 39'h400; h1_req_i = 1'b1; h1_addr_i = 39'h500; gnt_i = 1'b1;
        #1;
        checks++; if ({h0_gnt_o, h1_gnt_o} !== 2'b10) begin errors++; $display("FAIL order_gnt0: got %b exp 10", {h0_gnt_o, h1_gnt_o}); end
        @(negedge clk_i);
        h0_req_i = 1'b0;
        #1;
        checks++; if ({h0_gnt_o, h1_gnt_o} !== 2'b01) begin errors++; $display("FAIL order_gnt1: got %b exp 01", {h0_gnt_o, h1_gnt_o}); end
        @(negedge clk_i);
        h0_req_i = 1'b1;
        #1;
        checks++; if (req_o !== 1'b0) begin errors++; $display("FAIL order_full_req: got %b exp 0", req_o); end
        @(negedge clk_i);
        rvalid_i = 1'b1; rdata_i = 64'h1111;
        #1;
        checks++; if ({h0_rvalid_o, h1_rvalid_o} !== 2'b10) begin errors++; $display("FAIL order_resp1: got %b exp 10", {h0_rvalid_o, h1_rvalid_o}); end
        checks++; if (req_o !== 1'b0) begin errors++; $display("FAIL order_nobypass: got %b exp 0", req_o); end
        checks++; if ({h0_gnt_o, h1_gnt_o} !== 2'b00) begin errors++; $display("FAIL order_nogrant: got %b exp 00", {h0_gnt_o, h1_gnt_o}); end
        @(negedge clk_i);
        rvalid_i = 1'b0; gnt_i = 1'b0;
        #1;
        checks++; if (req_o !== 1'b1) begin errors++; $display("FAIL order_req_rise: got %b exp 1", req_o); end
        @(negedge clk_i);
        rvalid_i = 1'b1; rdata_i = 64'h2222;
        #1;
        checks++; if ({h0_rvalid_o, h1_rvalid_o} !== 2'b01) begin errors++; $display("FAIL order_resp2: got %b exp 01", {h0_rvalid_o, h1_rvalid_o}); end
        checks++; if (h1_rdata_o !== 64'h2222) begin errors++; $display("FAIL order_rdata2: got %h exp 2222", h1_rdata_o); end
        @(negedge clk_i);
        rvalid_i = 1'b0;
    endtask

    task automatic test_writes_untracked();
        do_reset();
        @(negedge clk_i);
        h0_req_i = 1'b1; h0_we_i = 1'b1; h0_addr_i = 39'h600; gnt_i = 1'b1;
        #1;
        checks++; if ({h0_gnt_o, we_o} !== 2'b11) begin errors++; $display("FAIL wr_gnt: got %b exp 11", {h0_gnt_o, we_o}); end
        @(negedge clk_i);
        h0_req_i = 1'b0; h0_we_i = 1'b0; h1_req_i = 1'b1; h1_addr_i = 39'h700;
        #1;
        checks++; if (h1_gnt_o !== 1'b1) begin errors++; $display("FAIL wr_rd1_gnt: got %b exp 1", h1_gnt_o); end
        @(negedge clk_i);
        h1_addr_i = 39'h708;
        #1;
        checks++; if (h1_gnt_o !== 1'b1) begin errors++; $display("FAIL wr_rd2_gnt: got %b exp 1", h1_gnt_o); end
        @(negedge clk_i);
        h1_addr_i = 39'h710;
        #1;
        checks++; if (req_o !== 1'b0) begin errors++; $display("FAIL wr_full_req: got %b exp 0", req_o); end
        @(negedge clk_i);
        h1_req_i = 1'b0; gnt_i = 1'b0; rvalid_i = 1'b1;
        #1;
        checks++; if ({h0_rvalid_o, h1_rvalid_o} !== 2'b01) begin errors++; $display("FAIL wr_resp: got %b exp 01", {h0_rvalid_o, h1_rvalid_o}); end
        @(negedge clk_i);
        rvalid_i = 1'b0;
    endtask

    task automatic test_spurious_and_reset();
        do_reset();
        @(negedge clk_i);
        rvalid_i = 1'b1;
        #1;
        checks++; if ({h0_rvalid_o, h1_rvalid_o} !== 2'b00) begin errors++; $display("FAIL spur_rvalid: got %b exp 00", {h0_rvalid_o, h1_rvalid_o}); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL spur_err_same: got %b exp 0", err_o); end
        @(negedge clk_i);
        rvalid_i = 1'b0;
        #1;
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL spur_err_set: got %b exp 1", err_o); end
        @(negedge clk_i);
        #1;
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL spur_err_hold: got %b exp 1", err_o); end
        @(negedge clk_i);
        h1_req_i = 1'b1; h1_addr_i = 39'h800; gnt_i = 1'b1;
        #1;
        checks++; if (h1_gnt_o !== 1'b1) begin errors++; $display("FAIL spur_rd_gnt: got %b exp 1", h1_gnt_o); end
        do_reset();
        #1;
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL spur_err_clr: got %b exp 0", err_o); end
        @(negedge clk_i);
        rvalid_i = 1'b1;
        #1;
        checks++; if (h1_rvalid_o !== 1'b0) begin errors++; $display("FAIL spur_post_reset_rvalid: got %b exp 0", h1_rvalid_o); end
        @(negedge clk_i);
        rvalid_i = 1'b0;
        #1;
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL spur_post_reset_err: got %b exp 1", err_o); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_contention_lock();
        test_simultaneous();
        test_ordered_routing();
        test_writes_untracked();
        test_spurious_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
